// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = $clog2(TIMEOUT_DEF);

  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Tie policy: round robin with ARB_ROUND_ROBIN_EN, else data wins.
module arb_pick
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic win
);

  logic tie_win;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_win = ~last_winner;
`else
  logic unused_last;
  assign unused_last = last_winner;
  assign tie_win     = REQ_DATA;
`endif

  always_comb begin
    win = REQ_FETCH;
    unique case (1'b1)
      req0 & req1:  win = tie_win;
      req1 & ~req0: win = REQ_DATA;
      default:      win = REQ_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch (0) vs data (1), with timeout.
// Tie policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sel_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            sel_q;
  logic            last_q;
  logic            gnt0_q;
  logic            gnt1_q;
  logic            done0_q;
  logic            done1_q;
  logic            err_q;
  logic [DATA_W-1:0] rdata_q;
  logic            win;
  logic            busy;
  logic            any_req;
  logic            cnt_last;

  arb_pick u_pick (
    .req0        (req0_i),
    .req1        (req1_i),
    .last_winner (last_q),
    .win         (win)
  );

  assign busy     = (state_q == BUSY);
  assign any_req  = req0_i | req1_i;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (mem_ready_i || cnt_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            sel_q  <= win;
            last_q <= win;
            gnt0_q <= ~win;
            gnt1_q <= win;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          // Ready beats the final timeout count.
          if (mem_ready_i) begin
            rdata_q <= mem_rdata_i;
            err_q   <= 1'b0;
            done0_q <= ~sel_q;
            done1_q <= sel_q;
          end else if (cnt_last) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            done0_q <= ~sel_q;
            done1_q <= sel_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign sel_o   = sel_q;

  assign mem_en_o    = busy;
  assign mem_we_o    = busy & sel_q & we1_i;
  assign mem_addr_o  = busy ? (sel_q ? addr1_i : addr0_i) : '0;
  assign mem_wdata_o = busy ? wdata1_i : '0;

endmodule
